main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm.sv | 170 +++++++++++++++++
 tb/tb_main_control_fsm.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Multicycle control FSM: registered state and state-decoded outputs.
// Optional MAIN_CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap instead of executing as a NOP.
module main_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] ALUop,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       pc_write,
    output logic       ir_write,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state;
    ctrl_t  ctrl;

    function automatic state_t next_state(input state_t s, input logic [6:0] op,
                                          input logic rdy);
        case (s)
            S_RST:      return S_FETCH;
            S_FETCH:    return rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: return S_MEMADR;
                    OP_RTYPE:          return S_EXECR;
                    OP_ITYPE:          return S_EXECI;
                    OP_BRANCH:         return S_BEQ;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
                    default:           return S_TRAP;
`else
                    default:           return S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   return (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  return rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    return S_FETCH;
            S_MEMWRITE: return rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR:    return S_ALUWB;
            S_EXECI:    return S_ALUWB;
            S_ALUWB:    return S_FETCH;
            S_BEQ:      return S_FETCH;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     return S_TRAP;
`endif
            default:    return S_FETCH;
        endcase
    endfunction

    // Opcode is stable from DECODE onward, so MEMADR may decode it on entry.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read = 1'b1;
                c.src_b    = 2'b10;
                c.alu_op   = 3'b010;
            end
            S_DECODE: begin
                c.src_a  = 2'b01;
                c.src_b  = 2'b01;
                c.alu_op = 3'b010;
            end
            S_MEMADR: begin
                c.src_a  = 2'b10;
                c.src_b  = 2'b01;
                c.alu_op = (op == OP_LOAD) ? 3'b010 : 3'b011;
            end
            S_MEMREAD: begin
                c.adr_src  = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.src_a  = 2'b10;
                c.alu_op = 3'b100;
            end
            S_EXECI: begin
                c.src_a  = 2'b10;
                c.src_b  = 2'b01;
                c.alu_op = 3'b001;
            end
            S_ALUWB:  c.reg_write = 1'b1;
            S_BEQ:    c.src_a = 2'b10;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:   c.illegal = 1'b1;
`endif
            default:  c = '0;
        endcase
        return c;
    endfunction

    // NOTE: outputs are registered from the next state so they line up with the
    // state register and still look like a pure decode of the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
            ctrl  <= '0;
        end else begin
            state <= next_state(state, opcode, mem_ready);
            ctrl  <= ctrl_for(next_state(state, opcode, mem_ready), opcode);
        end
    end

    // Only the handshake-dependent strobes are combinational on the current state.
    assign ir_write = (state == S_FETCH) && mem_ready;
    assign pc_write = ir_write || ((state == S_BEQ) && zero);

    assign ALUop         = ctrl.alu_op;
    assign alu_src_a     = ctrl.src_a;
    assign alu_src_b     = ctrl.src_b;
    assign result_src    = ctrl.result_src;
    assign adr_src       = ctrl.adr_src;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign reg_write     = ctrl.reg_write;
    assign illegal_instr = ctrl.illegal;
    assign state_o       = state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Table-driven bench for main_control_fsm plus a hand sequence for mid-access reset.
module tb_main_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res;
        logic       adr;
        logic       mrd;
        logic       mwr;
        logic       rw;
        logic       pcw;
        logic       irw;
        logic       ill;
    } out_t;

    typedef struct {
        logic       rst_n;
        logic [6:0] opcode;
        logic       zero;
        logic       mem_ready;
        out_t       exp;
    } vec_t;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    //                         st     aluop   a      b      res    adr   mrd   mwr   rw    pcw   irw   ill
    localparam out_t E_RST   = '{4'd0,  3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_FWAIT = '{4'd1,  3'b010, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_FETCH = '{4'd1,  3'b010, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam out_t E_DEC   = '{4'd2,  3'b010, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_MA_LD = '{4'd3,  3'b010, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_MA_ST = '{4'd3,  3'b011, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_MRD   = '{4'd4,  3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_MWB   = '{4'd5,  3'b000, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam out_t E_MWR   = '{4'd6,  3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_EXR   = '{4'd7,  3'b100, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_EXI   = '{4'd8,  3'b001, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_AWB   = '{4'd9,  3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam out_t E_BEQ_T = '{4'd10, 3'b000, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam out_t E_BEQ_N = '{4'd10, 3'b000, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_TRAP  = '{4'd11, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] ALUop;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic       adr_src, mem_read, mem_write, reg_write, pc_write, ir_write, illegal_instr;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[$];

    main_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .ALUop(ALUop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .adr_src(adr_src), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .pc_write(pc_write),
        .ir_write(ir_write), .illegal_instr(illegal_instr), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic rn, input logic [6:0] op, input logic z,
                               input logic mr, input out_t e);
        vec_t r;
        r.rst_n = rn; r.opcode = op; r.zero = z; r.mem_ready = mr; r.exp = e;
        return r;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = '{state_o, ALUop, alu_src_a, alu_src_b, result_src, adr_src,
                mem_read, mem_write, reg_write, pc_write, ir_write, illegal_instr};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drive on the falling edge, sample 1 time unit later; the rising edge then advances the FSM.
    task automatic step(input string name, input logic rn, input logic [6:0] op,
                        input logic z, input logic mr, input out_t exp);
        @(negedge clk);
        rst_n = rn; opcode = op; zero = z; mem_ready = mr;
        #1;
        check(name, exp);
    endtask

    initial begin
        vecs.push_back(v(1'b0, OP_LD,  1'b0, 1'b1, E_RST));
        vecs.push_back(v(1'b0, OP_LD,  1'b0, 1'b1, E_RST));
        vecs.push_back(v(1'b1, OP_LD,  1'b0, 1'b1, E_RST));
        // load with fetch wait and two MEMREAD wait states
        vecs.push_back(v(1'b1, OP_LD,  1'b0, 1'b0, E_FWAIT));
        vecs.push_back(v(1'b1, OP_LD,  1'b0, 1'b1, E_FETCH));
        vecs.push_back(v(1'b1, OP_LD,  1'b0, 1'b0, E_DEC));
        vecs.push_back(v(1'b1, OP_LD,  1'b0, 1'b0, E_MA_LD));
        vecs.push_back(v(1'b1, OP_LD,  1'b0, 1'b0, E_MRD));
        vecs.push_back(v(1'b1, OP_LD,  1'b0, 1'b0, E_MRD));
        vecs.push_back(v(1'b1, OP_LD,  1'b0, 1'b1, E_MRD));
        vecs.push_back(v(1'b1, OP_LD,  1'b0, 1'b1, E_MWB));
        // store, no wait
        vecs.push_back(v(1'b1, OP_ST,  1'b0, 1'b1, E_FETCH));
        vecs.push_back(v(1'b1, OP_ST,  1'b0, 1'b1, E_DEC));
        vecs.push_back(v(1'b1, OP_ST,  1'b0, 1'b1, E_MA_ST));
        vecs.push_back(v(1'b1, OP_ST,  1'b0, 1'b1, E_MWR));
        // R-type then I-type
        vecs.push_back(v(1'b1, OP_R,   1'b0, 1'b1, E_FETCH));
        vecs.push_back(v(1'b1, OP_R,   1'b0, 1'b1, E_DEC));
        vecs.push_back(v(1'b1, OP_R,   1'b0, 1'b1, E_EXR));
        vecs.push_back(v(1'b1, OP_R,   1'b0, 1'b1, E_AWB));
        vecs.push_back(v(1'b1, OP_I,   1'b0, 1'b1, E_FETCH));
        vecs.push_back(v(1'b1, OP_I,   1'b0, 1'b1, E_DEC));
        vecs.push_back(v(1'b1, OP_I,   1'b0, 1'b1, E_EXI));
        vecs.push_back(v(1'b1, OP_I,   1'b0, 1'b1, E_AWB));
        // branch taken, then not taken
        vecs.push_back(v(1'b1, OP_BR,  1'b1, 1'b1, E_FETCH));
        vecs.push_back(v(1'b1, OP_BR,  1'b1, 1'b1, E_DEC));
        vecs.push_back(v(1'b1, OP_BR,  1'b1, 1'b1, E_BEQ_T));
        vecs.push_back(v(1'b1, OP_BR,  1'b0, 1'b1, E_FETCH));
        vecs.push_back(v(1'b1, OP_BR,  1'b0, 1'b1, E_DEC));
        vecs.push_back(v(1'b1, OP_BR,  1'b0, 1'b1, E_BEQ_N));
        // store with one wait state
        vecs.push_back(v(1'b1, OP_ST,  1'b0, 1'b1, E_FETCH));
        vecs.push_back(v(1'b1, OP_ST,  1'b0, 1'b1, E_DEC));
        vecs.push_back(v(1'b1, OP_ST,  1'b0, 1'b0, E_MA_ST));
        vecs.push_back(v(1'b1, OP_ST,  1'b0, 1'b0, E_MWR));
        vecs.push_back(v(1'b1, OP_ST,  1'b0, 1'b1, E_MWR));
        // illegal opcode
        vecs.push_back(v(1'b1, OP_BAD, 1'b0, 1'b1, E_FETCH));
        vecs.push_back(v(1'b1, OP_BAD, 1'b0, 1'b1, E_DEC));
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        vecs.push_back(v(1'b1, OP_BAD, 1'b0, 1'b1, E_TRAP));
        vecs.push_back(v(1'b1, OP_LD,  1'b1, 1'b0, E_TRAP));
        vecs.push_back(v(1'b1, OP_LD,  1'b0, 1'b1, E_TRAP));
`else
        vecs.push_back(v(1'b1, OP_BAD, 1'b0, 1'b1, E_FETCH));
        vecs.push_back(v(1'b1, OP_BAD, 1'b0, 1'b1, E_DEC));
        vecs.push_back(v(1'b1, OP_BAD, 1'b0, 1'b1, E_FETCH));
`endif

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec[%0d]", i), vecs[i].rst_n, vecs[i].opcode,
                 vecs[i].zero, vecs[i].mem_ready, vecs[i].exp);

        // Reset asserted mid-MEMREAD: abandon the load, clear outputs at once.
        step("pre_rst",   1'b0, OP_LD, 1'b0, 1'b1, E_RST);
        step("pre_rel",   1'b1, OP_LD, 1'b0, 1'b1, E_RST);
        step("ld_fetch",  1'b1, OP_LD, 1'b0, 1'b1, E_FETCH);
        step("ld_dec",    1'b1, OP_LD, 1'b0, 1'b0, E_DEC);
        step("ld_madr",   1'b1, OP_LD, 1'b0, 1'b0, E_MA_LD);
        step("ld_wait",   1'b1, OP_LD, 1'b0, 1'b0, E_MRD);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", E_RST);
        step("rst_hold0", 1'b0, OP_LD, 1'b0, 1'b1, E_RST);
        step("rst_hold1", 1'b0, OP_LD, 1'b0, 1'b1, E_RST);
        step("rst_hold2", 1'b0, OP_LD, 1'b0, 1'b1, E_RST);
        step("rst_rel",   1'b1, OP_LD, 1'b0, 1'b1, E_RST);
        step("rel_fetch", 1'b1, OP_LD, 1'b0, 1'b1, E_FETCH);
        step("rel_dec",   1'b1, OP_LD, 1'b0, 1'b1, E_DEC);
        step("rel_madr",  1'b1, OP_LD, 1'b0, 1'b1, E_MA_LD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
